// File: rtl/mult_seq_ctrl.sv
// Sequential 32x32 shift-add multiplier with sign correction and HI/LO result registers.
// Optional MULT_EARLY_TERM_EN: stop iterating once the remaining multiplier bits are all zero.
module mult_seq_ctrl (
    input  logic        CLK,
    input  logic        RST,
    input  logic        START,
    input  logic        SIGNED,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        BUSY,
    output logic        DONE,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    typedef enum logic [1:0] {StIdle, StIter, StFix, StDone} state_e;

    state_e      state_q, state_d;
    logic [63:0] mcand_q, mcand_d;
    logic [31:0] mplier_q, mplier_d;
    logic [63:0] prod_q, prod_d;
    logic [4:0]  cnt_q, cnt_d;
    logic        neg_q, neg_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;

    logic [31:0] a_abs, b_abs;
    logic [31:0] mplier_shift;
    logic        accept;
    logic        start_to_fix;
    logic        iter_last;

    // 0x80000000 negates to itself, which is its correct unsigned magnitude.
    assign a_abs        = (SIGNED && A[31]) ? (~A + 32'd1) : A;
    assign b_abs        = (SIGNED && B[31]) ? (~B + 32'd1) : B;
    assign mplier_shift = mplier_q >> 1;
    assign accept       = START && ((state_q == StIdle) || (state_q == StDone));

`ifdef MULT_EARLY_TERM_EN
    assign start_to_fix = (b_abs == 32'd0);
    assign iter_last    = (cnt_q == 5'd31) || (mplier_shift == 32'd0);
`else
    assign start_to_fix = 1'b0;
    assign iter_last    = (cnt_q == 5'd31);
`endif

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle, StDone: begin
                if (START) begin
                    state_d = start_to_fix ? StFix : StIter;
                end else begin
                    state_d = StIdle;
                end
            end
            StIter: begin
                if (iter_last) begin
                    state_d = StFix;
                end
            end
            StFix:   state_d = StDone;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        BUSY = (state_q == StIter) || (state_q == StFix);
        DONE = (state_q == StDone);
        HI   = hi_q;
        LO   = lo_q;
    end

    always_comb begin
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        prod_d   = prod_q;
        cnt_d    = cnt_q;
        neg_d    = neg_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        if (accept) begin
            mcand_d  = {32'd0, a_abs};
            mplier_d = b_abs;
            prod_d   = 64'd0;
            cnt_d    = 5'd0;
            neg_d    = SIGNED && (A[31] ^ B[31]);
        end else if (state_q == StIter) begin
            if (mplier_q[0]) begin
                prod_d = prod_q + mcand_q;
            end
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_shift;
            cnt_d    = cnt_q + 5'd1;
        end else if (state_q == StFix) begin
            {hi_d, lo_d} = neg_q ? (~prod_q + 64'd1) : prod_q;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            mcand_q  <= 64'd0;
            mplier_q <= 32'd0;
            prod_q   <= 64'd0;
            cnt_q    <= 5'd0;
            neg_q    <= 1'b0;
            hi_q     <= 32'd0;
            lo_q     <= 32'd0;
        end else begin
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            prod_q   <= prod_d;
            cnt_q    <= cnt_d;
            neg_q    <= neg_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
        end
    end

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// Scoreboard bench for mult_seq_ctrl: directed products, latency, handshake and reset abort.
module tb_mult_seq_ctrl;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        START = 1'b0;
    logic        SIGNED = 1'b0;
    logic [31:0] A = 32'd0;
    logic [31:0] B = 32'd0;
    logic        BUSY;
    logic        DONE;
    logic [31:0] HI;
    logic [31:0] LO;

    int unsigned checks = 0;
    int unsigned errors = 0;
    int unsigned cyc = 0;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int unsigned done_cyc;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    mult_seq_ctrl u_dut (
        .CLK    (CLK),
        .RST    (RST),
        .START  (START),
        .SIGNED (SIGNED),
        .A      (A),
        .B      (B),
        .BUSY   (BUSY),
        .DONE   (DONE),
        .HI     (HI),
        .LO     (LO)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc++;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Edges from the START sample to the edge that ends the FIX state.
    function automatic int unsigned exp_lat(input logic s, input logic [31:0] b);
        logic [31:0] m;
        int unsigned n;
        m = (s && b[31]) ? (~b + 32'd1) : b;
        n = 0;
        for (int i = 0; i < 32; i++) begin
            if (m[i]) n = i + 1;
        end
`ifndef MULT_EARLY_TERM_EN
        n = 32;
`endif
        return n + 1;
    endfunction

    // Monitor: every DONE pulse must match the oldest outstanding expectation.
    always @(negedge CLK) begin
        if (RST && DONE) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL spurious_done: got DONE=1 at cycle %0d expected no DONE", cyc);
            end else begin
                mon_e = sb.pop_front();
                chk("hi", {32'd0, HI}, {32'd0, mon_e.hi});
                chk("lo", {32'd0, LO}, {32'd0, mon_e.lo});
                chk("done_cycle", 64'(cyc), 64'(mon_e.done_cyc));
            end
        end
    end

    // Called at a negedge; returns at the negedge right after the sampling edge.
    task automatic issue(input logic s, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] hi, input logic [31:0] lo);
        exp_t e;
        START  = 1'b1;
        SIGNED = s;
        A      = a;
        B      = b;
        @(negedge CLK);
        START  = 1'b0;
        SIGNED = ~s;
        A      = $urandom;
        B      = $urandom;
        e.hi       = hi;
        e.lo       = lo;
        e.done_cyc = cyc + exp_lat(s, b);
        sb.push_back(e);
    endtask

    task automatic wait_done();
        int k;
        k = 0;
        while (!DONE && k < 100) begin
            @(negedge CLK);
            k++;
        end
        if (!DONE) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: got DONE=0 after %0d cycles expected DONE=1", k);
        end
    endtask

    task automatic run(input logic s, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] hi, input logic [31:0] lo);
        issue(s, a, b, hi, lo);
        wait_done();
        @(negedge CLK);
    endtask

    initial begin
        repeat (3) @(negedge CLK);
        chk("rst_busy", {63'd0, BUSY}, 64'd0);
        chk("rst_done", {63'd0, DONE}, 64'd0);
        chk("rst_hi", {32'd0, HI}, 64'd0);
        chk("rst_lo", {32'd0, LO}, 64'd0);
        RST = 1'b1;
        @(negedge CLK);

        run(1'b0, 32'd5, 32'd7, 32'h0000_0000, 32'h0000_0023);
        run(1'b1, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
        run(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
        run(1'b1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000);
        run(1'b0, 32'h1234_5678, 32'd0, 32'h0000_0000, 32'h0000_0000);

        // START re-pulsed mid-operation with different operands is ignored.
        issue(1'b0, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0000_0000);
        repeat (9) @(negedge CLK);
        START  = 1'b1;
        SIGNED = 1'b1;
        A      = 32'd3;
        B      = 32'd3;
        @(negedge CLK);
        START  = 1'b0;
        wait_done();
        @(negedge CLK);

        // START during the DONE cycle starts the next multiply back-to-back.
        issue(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001);
        wait_done();
        issue(1'b0, 32'h1234_5678, 32'h0000_0010, 32'h0000_0001, 32'h2345_6780);
        wait_done();
        @(negedge CLK);

        run(1'b1, 32'd100, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FF9C);

        // Asynchronous abort after E15.
        issue(1'b1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFF2);
        repeat (14) @(negedge CLK);
        chk("hold_hi", {32'd0, HI}, {32'd0, 32'hFFFF_FFFF});
        chk("hold_lo", {32'd0, LO}, {32'd0, 32'hFFFF_FF9C});
        @(posedge CLK);
        #1;
        sb.delete();
        RST = 1'b0;
        #1;
        chk("abort_busy", {63'd0, BUSY}, 64'd0);
        chk("abort_done", {63'd0, DONE}, 64'd0);
        chk("abort_hi", {32'd0, HI}, 64'd0);
        chk("abort_lo", {32'd0, LO}, 64'd0);
        @(negedge CLK);
        RST = 1'b1;
        repeat (40) @(negedge CLK);

        run(1'b1, 32'h7FFF_FFFF, 32'd2, 32'h0000_0000, 32'hFFFF_FFFE);

        repeat (3) @(negedge CLK);
        chk("drain", 64'(sb.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
